// File: rtl/serializer_if.sv
// serializer_if -- word-side handshake and serial-side strobe of the serializer.
//
//   data_i         : parallel word, bit 0 leaves first
//   data_mod_i     : word length in bits (0 or > SER_W means SER_W)
//   data_val_i     : word valid, accepted when data_val_i && ready_o
//   ready_o        : serializer can take a word this cycle
//   ser_data_o     : serial bit
//   ser_data_val_o : ser_data_o is valid this cycle
//
// master modport = upstream word source; slave modport = serializer.
interface serializer_if #(
    parameter int SER_W = 16,
    parameter int MOD_W = $clog2(SER_W + 1)
);
    logic [SER_W-1:0] data_i;
    logic [MOD_W-1:0] data_mod_i;
    logic             data_val_i;
    logic             ready_o;
    logic             ser_data_o;
    logic             ser_data_val_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ready_o,
        input  ser_data_o,
        input  ser_data_val_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ready_o,
        output ser_data_o,
        output ser_data_val_o
    );
endinterface

// File: rtl/serializer.sv
// serializer -- parallel-to-serial converter, LSB first, one bit per clock.
//
// Ports:
//   clk_i  : clock, rising edge
//   srst_i : asynchronous active-high reset; drops any word in flight
//   bus    : serializer_if.slave (word handshake in, serial bit + strobe out)
//
// A word is loaded on acceptance and shifted out starting the next cycle.
// ready_o rises again in the last-bit cycle so a following word can be
// loaded on that same edge, giving a gap-free bit stream.
module serializer #(
    parameter int SER_W = 16,
    parameter int MOD_W = $clog2(SER_W + 1)
) (
    input  logic          clk_i,
    input  logic          srst_i,
    serializer_if.slave   bus
);

    localparam logic [MOD_W-1:0] FULL_LEN = MOD_W'(SER_W);
    localparam logic [MOD_W-1:0] ONE      = MOD_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SER_W-1:0] shreg_q, shreg_d;
    logic [MOD_W-1:0] bits_left_q, bits_left_d;

    logic             last_bit;
    logic             ready;
    logic             accept;
    logic [MOD_W-1:0] eff_len;

    // ready depends only on registered state, never on data_val_i
    assign last_bit = (state_q == SHIFT) && (bits_left_q == ONE);
    assign ready    = (state_q == IDLE) || last_bit;
    assign accept   = bus.data_val_i && ready;

    // 0 and out-of-range lengths both mean a full word
    always_comb begin
        eff_len = bus.data_mod_i;
        if (bus.data_mod_i == '0 || bus.data_mod_i > FULL_LEN) begin
            eff_len = FULL_LEN;
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    shreg_d     = bus.data_i;
                    bits_left_d = eff_len;
                end
            end
            SHIFT: begin
                if (accept) begin
                    // reload on the last-bit edge: no idle cycle between words
                    shreg_d     = bus.data_i;
                    bits_left_d = eff_len;
                end else begin
                    shreg_d     = {1'b0, shreg_q[SER_W-1:1]};
                    bits_left_d = bits_left_q - ONE;
                    if (last_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output is forced low in IDLE rather than exposing the stale shreg bit
    assign bus.ready_o        = ready;
    assign bus.ser_data_val_o = (state_q == SHIFT);
    assign bus.ser_data_o     = (state_q == SHIFT) ? shreg_q[0] : 1'b0;

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial converter, the transmit-side counterpart of the `deserializer` block. It accepts a word of up to `SER_W` bits through a valid/ready handshake and shifts it out one bit per clock, LSB first, with a per-bit valid strobe. Its `ser_data_o`/`ser_data_val_o` pair connects directly to `data_i`/`data_val_i` of `deserializer`, and the loopback reproduces the original words.

## Interface
- `SER_W`, default 16: maximum word width in bits; must be ≥ 2.
- `MOD_W`, default `$clog2(SER_W+1)`: width of `data_mod_i`.

- `clk_i`, input, 1: clock; all logic on the rising edge.
- `srst_i`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `data_i`, input, `SER_W`: parallel word; bit 0 is transmitted first.
- `data_mod_i`, input, `MOD_W`: number of bits to transmit. 0 means `SER_W`; values above `SER_W` are clamped to `SER_W`.
- `data_val_i`, input, 1: word valid; the word is accepted when `data_val_i && ready_o`.
- `ready_o`, output, 1: the block can accept a word this cycle.
- `ser_data_o`, output, 1: serial data bit.
- `ser_data_val_o`, output, 1: `ser_data_o` is valid this cycle.

## Operation
- State machine with two states: IDLE and SHIFT. Internal registers: a `SER_W` shift register and a `bits_left` counter, `MOD_W` bits wide.
- Effective length: N = (`data_mod_i` == 0 || `data_mod_i` > `SER_W`) ? `SER_W` : `data_mod_i`.
- IDLE → SHIFT on acceptance. The shift register loads `data_i` and `bits_left` loads N.
- In SHIFT, each cycle:
  - `ser_data_o` = shreg[0] and `ser_data_val_o` = 1.
  - On the clock edge, the shift register shifts right by one and `bits_left` decrements.
- `ready_o` = (state == IDLE) || (state == SHIFT && `bits_left` == 1). It is combinational from registered state only.
- Last-bit cycle (`bits_left` == 1):
  - If a word is accepted, the block reloads and stays in SHIFT, so there is no gap.
  - Otherwise it returns to IDLE.
- `data_val_i` while `ready_o` = 0 is ignored. The upstream block must hold the word until accepted.
- `data_i` and `data_mod_i` are sampled only at acceptance. Later changes have no effect on the word in flight.
- In IDLE: `ser_data_val_o` = 0 and `ser_data_o` = 0. The output is forced to 0, not the stale shift-register bit.
- Reset (asserted at any time, including mid-word):
  - State = IDLE, shift register = 0, `bits_left` = 0, immediately without waiting for a clock.
  - The word in flight is discarded with no partial continuation.
  - Inputs are ignored while `srst_i` is high.
- Reset values of the outputs: `ser_data_o` = 0, `ser_data_val_o` = 0, `ready_o` = 1.

## Timing
- Acceptance at rising edge k → first bit on `ser_data_o` in cycle k+1, i.e. latency 1 cycle.
- Bit i (0 ≤ i < N) is driven in cycle k+1+i. `ser_data_val_o` is high for exactly N consecutive cycles.
- `ready_o` is low in cycles k+1 … k+N−1 and high in cycle k+N (the last bit).
- For N = 1, `ready_o` stays high throughout: one bit per accepted word, and back-to-back acceptance is possible every cycle.
- Sustained throughput with back-to-back words: 1 bit per clock, with no idle cycle between words.
- Deassertion of `srst_i` takes effect on the next rising edge. The first acceptance is possible at that edge.

## Test plan
- Single full word: `data_i` = 16'hA5C3, `data_mod_i` = 0 → 16 valid cycles starting 1 cycle after acceptance; bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; then `ser_data_val_o` = 0 and `ready_o` = 1.
- Partial and clamped lengths: `data_mod_i` = 5 with `data_i` = 16'h0013 → bits 1,1,0,0,1, then idle. Repeat with `data_mod_i` = 1 (1 bit) and `data_mod_i` = 31 (clamped, 16 bits).
- Back-to-back words: hold `data_val_i` = 1 with 16'hFFFF, then 16'h0000 → 32 contiguous valid cycles (16 ones, then 16 zeros); `ready_o` is high only in the two last-bit cycles.
- Busy and input-stability checks:
  - Pulse `data_val_i` with a new word while mid-word (`bits_left` > 1) → ignored; the current word completes unchanged.
  - Change `data_i` after acceptance → no effect on the output.
- Asynchronous reset mid-word: assert `srst_i` between clock edges after bit 7 of 16 → `ser_data_val_o` = 0 and `ready_o` = 1 immediately. After release, a new word 16'h1234 transmits correctly from bit 0.
- Loopback with `deserializer` (`DESER_W` = 16): 50 random words, each with `data_mod_i` = 0 → every `deser_data_o` equals the corresponding sent word.
